// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter_pkg
//   Shared types for the data-bus arbiter: request/response bundles used on
//   the instruction-fetch, memory-stage and downstream ports, the arbiter
//   state encoding, and a saturating helper for the starvation counter.
package dbus_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_W   = 3;
  localparam int STARVE_W = 3;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_e;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [STARVE_W-1:0] starve_inc(
    input logic [STARVE_W-1:0] cnt,
    input logic [STARVE_W-1:0] limit
  );
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/dbus_arbiter.sv
// dbus_arbiter
//   Two-port to one-port bus arbiter. The memory-stage (data) port normally
//   wins over the instruction-fetch port, but after STARVE_LIMIT consecutive
//   data grants taken while instruction fetch was waiting, fetch is served.
//   While a port is granted, its request is passed straight through to the
//   downstream bus and the downstream response is passed straight back.
//
// Ports
//   clk      clock, all state changes on rising edge
//   rst      asynchronous active-high reset
//   ireq     instruction-fetch request      iresp  its response
//   dreq     memory-stage request           dresp  its response
//   oreq     shared downstream request      oresp  downstream response
//   busy     a port is currently granted
//   grant_d  the memory-stage port is granted (fetch grant = busy & ~grant_d)
//
// STARVE_LIMIT must fit the 3-bit starvation counter (0..7). A value of 0
// gives the fetch port strict priority whenever both ports request.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  ireq,
  output dbus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  oreq,
  input  dbus_resp_t oresp,
  output logic       busy,
  output logic       grant_d
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                busy_q, busy_d;
  logic                grant_d_q, grant_d_d;

  // Next-state and starvation bookkeeping.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ARB_IDLE: begin
        // Data wins unless fetch is also waiting and has been passed over
        // LIMIT times already.
        if (dreq.valid && !(ireq.valid && (starve_q == LIMIT))) begin
          state_d = ARB_SERVE_D;
          if (ireq.valid) begin
            starve_d = starve_inc(starve_q, LIMIT);
          end
        end else if (ireq.valid) begin
          state_d  = ARB_SERVE_I;
          starve_d = '0;
        end
      end
      // Completion and abort (requester dropping valid) both return to IDLE;
      // an abort leaves the starvation counter alone.
      ARB_SERVE_I: begin
        if (oresp.data_ok || !ireq.valid) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_SERVE_D: begin
        if (oresp.data_ok || !dreq.valid) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d    = (state_d != ARB_IDLE);
    grant_d_d = (state_d == ARB_SERVE_D);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      starve_q  <= '0;
      busy_q    <= 1'b0;
      grant_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      busy_q    <= busy_d;
      grant_d_q <= grant_d_d;
    end
  end

  // Pass-through muxing keyed on the registered state, so reset silences all
  // ports immediately and responses arriving in IDLE are dropped.
  always_comb begin
    oreq  = '0;
    iresp = '0;
    dresp = '0;
    case (state_q)
      ARB_SERVE_I: begin
        oreq  = ireq;
        iresp = oresp;
      end
      ARB_SERVE_D: begin
        oreq  = dreq;
        dresp = oresp;
      end
      default: begin
      end
    endcase
  end

  assign busy    = busy_q;
  assign grant_d = grant_d_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter
//   Directed scenarios for reset, single fetch, store while fetch waits,
//   abort, stray responses and reset mid-transaction, followed by a random
//   phase in which both ports stream transactions against a randomly delayed
//   downstream responder and a scoreboard checks grant order and data.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic       clk;
  logic       rst;
  dbus_req_t  ireq, dreq, oreq;
  dbus_resp_t iresp, dresp, oresp;
  logic       busy, grant_d;

  int checks = 0;
  int errors = 0;
  bit auto_mode = 0;

  typedef struct {
    bit                is_d;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } exp_t;

  exp_t      exp_q[$];
  dbus_req_t iq[$];
  dbus_req_t dq[$];
  int        txn_no = 0;

  dbus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .ireq   (ireq),
    .iresp  (iresp),
    .dreq   (dreq),
    .dresp  (dresp),
    .oreq   (oreq),
    .oresp  (oresp),
    .busy   (busy),
    .grant_d(grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream responder: data_ok after 0..2 extra cycles of a grant, plus
  // occasional stray responses while nothing is granted.
  initial begin
    int wait_cnt = 0;
    int target   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_mode) begin
        oresp = '0;
        if (oreq.valid) begin
          oresp.addr_ok = (wait_cnt == 0);
          if (wait_cnt == target) begin
            oresp.data_ok = 1'b1;
            oresp.data    = {$urandom, $urandom};
            wait_cnt      = 0;
            target        = $urandom_range(0, 2);
          end else begin
            wait_cnt++;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          oresp.data_ok = 1'b1;
          oresp.addr_ok = 1'b1;
          oresp.data    = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor / scoreboard for the random phase.
  always @(negedge clk) begin
    if (auto_mode) begin
      if (!busy) begin
        chk("idle_oreq", 128'(oreq), 128'(0));
        chk("idle_iresp", 128'(iresp), 128'(0));
        chk("idle_dresp", 128'(dresp), 128'(0));
      end else begin
        chk("serve_valid", 128'(oreq.valid), 128'(1));
        if (grant_d) chk("ungranted_iresp", 128'(iresp), 128'(0));
        else         chk("ungranted_dresp", 128'(dresp), 128'(0));
        if (iresp.data_ok || dresp.data_ok) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got unexpected completion expected none");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            txn_no++;
            $display("txn %0d port=%s addr=%h wdata=%h", txn_no,
                     e.is_d ? "D" : "I", e.addr, e.wdata);
            chk("sb_port", 128'(dresp.data_ok), 128'(e.is_d));
            chk("sb_addr", 128'(oreq.addr), 128'(e.addr));
            chk("sb_wdata", 128'(oreq.data), 128'(e.wdata));
            chk("sb_rdata", 128'(e.is_d ? dresp.data : iresp.data), 128'(oresp.data));
          end
        end
      end
    end
  end

  // Streams one port's transactions; the next one is presented in the idle
  // bubble right after the previous completes.
  task automatic drive(input bit is_d);
    dbus_req_t q[$];
    q = is_d ? dq : iq;
    foreach (q[k]) begin
      int  n = 0;
      bit  done = 0;
      if (is_d) dreq = q[k];
      else      ireq = q[k];
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
        done = is_d ? dresp.data_ok : iresp.data_ok;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: got no data_ok on port %s expected completion", is_d ? "D" : "I");
        break;
      end
      tick();
    end
    if (is_d) dreq.valid = 1'b0;
    else      ireq.valid = 1'b0;
  endtask

  initial begin
    int pulses;
    bit i_dirty;
    logic [DATA_W-1:0] rd;
    rst   = 1'b1;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    repeat (2) tick();
    chk("rst_oreq_valid", 128'(oreq.valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant_d", 128'(grant_d), 128'(0));
    chk("rst_iresp", 128'(iresp), 128'(0));
    chk("rst_dresp", 128'(dresp), 128'(0));
    rst = 1'b0;

    // Single fetch, downstream answers in the second serve cycle.
    ireq = '{valid: 1'b1, addr: 32'h8000_0000, size: 3'd2, strobe: 8'h00, data: 64'h0};
    tick();
    chk("fetch_busy", 128'(busy), 128'(1));
    chk("fetch_grant_d", 128'(grant_d), 128'(0));
    chk("fetch_oreq_addr", 128'(oreq.addr), 128'(32'h8000_0000));
    chk("fetch_oreq_valid", 128'(oreq.valid), 128'(1));
    tick();
    rd = {$urandom, $urandom};
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: rd};
    #1;
    chk("fetch_iresp_data", 128'(iresp.data), 128'(rd));
    chk("fetch_iresp_ok", 128'(iresp.data_ok), 128'(1));
    chk("fetch_dresp_zero", 128'(dresp), 128'(0));
    tick();
    oresp = '0;
    ireq.valid = 1'b0;
    chk("fetch_done_busy", 128'(busy), 128'(0));
    chk("fetch_done_oreq", 128'(oreq), 128'(0));

    // Stray response while idle.
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1234_5678_9ABC_DEF0};
    #1;
    chk("stray_iresp", 128'(iresp), 128'(0));
    chk("stray_dresp", 128'(dresp), 128'(0));
    tick();
    chk("stray_busy", 128'(busy), 128'(0));
    oresp = '0;

    // Store on the data port while fetch also waits.
    ireq = '{valid: 1'b1, addr: 32'h8000_0040, size: 3'd2, strobe: 8'h00, data: 64'h0};
    dreq = '{valid: 1'b1, addr: 32'h1000_0000, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_BEEF};
    tick();
    chk("store_grant_d", 128'(grant_d), 128'(1));
    chk("store_strobe", 128'(oreq.strobe), 128'(8'hFF));
    chk("store_data", 128'(oreq.data), 128'(64'hDEAD_BEEF));
    pulses  = 0;
    i_dirty = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
      else        oresp = '0;
      #1;
      if (dresp.data_ok) pulses++;
      if (iresp != '0) i_dirty = 1;
      tick();
      if (k == 1) begin
        dreq.valid = 1'b0;
        ireq.valid = 1'b0;
      end
    end
    chk("store_dok_pulses", 128'(pulses), 128'(1));
    chk("store_iresp_quiet", 128'(i_dirty), 128'(0));

    // Data port aborts before data_ok.
    dreq.valid = 1'b1;
    tick();
    chk("abort_pre_valid", 128'(oreq.valid), 128'(1));
    dreq.valid = 1'b0;
    #1;
    chk("abort_oreq_valid", 128'(oreq.valid), 128'(0));
    chk("abort_still_busy", 128'(busy), 128'(1));
    tick();
    chk("abort_idle", 128'(busy), 128'(0));

    // Reset one cycle into a fetch, with a data request pending.
    ireq = '{valid: 1'b1, addr: 32'h8000_0100, size: 3'd2, strobe: 8'h00, data: 64'h0};
    tick();
    chk("rst_mid_busy_before", 128'(busy), 128'(1));
    tick();
    dreq = '{valid: 1'b1, addr: 32'h2000_0000, size: 3'd3, strobe: 8'h0F, data: 64'h55};
    rst  = 1'b1;
    #1;
    chk("rst_mid_oreq_valid", 128'(oreq.valid), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_grant_d", 128'(grant_d), 128'(0));
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hFFFF};
    #1;
    chk("rst_mid_iresp", 128'(iresp), 128'(0));
    ireq.valid = 1'b0;
    oresp = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_after_grant_d", 128'(grant_d), 128'(1));
    chk("rst_after_addr", 128'(oreq.addr), 128'(32'h2000_0000));
    oresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0};
    tick();
    dreq.valid = 1'b0;
    oresp = '0;

    // Random streaming phase. Expected grant order follows from the rule:
    // with both ports pending, data wins until it has won LIMIT times in a
    // row over a waiting fetch, then fetch wins once.
    begin
      int ni, nd, ii, di, cnt;
      dbus_req_t r;
      ni = $urandom_range(6, 14);
      nd = $urandom_range(10, 24);
      for (int k = 0; k < ni + nd; k++) begin
        r.valid  = 1'b1;
        r.addr   = {$urandom} & 32'hFFFF_FFF8;
        r.size   = 3'($urandom_range(0, 3));
        r.strobe = 8'($urandom);
        r.data   = {$urandom, $urandom};
        if (k < ni) iq.push_back(r);
        else        dq.push_back(r);
      end
      ii = 0; di = 0; cnt = 0;
      while (ii < ni || di < nd) begin
        bit pick_d;
        if (ii < ni && di < nd) begin
          pick_d = (cnt != LIMIT);
          cnt    = pick_d ? ((cnt < LIMIT) ? cnt + 1 : cnt) : 0;
        end else if (di < nd) begin
          pick_d = 1;
        end else begin
          pick_d = 0;
          cnt    = 0;
        end
        if (pick_d) begin
          exp_q.push_back('{is_d: 1'b1, addr: dq[di].addr, wdata: dq[di].data});
          di++;
        end else begin
          exp_q.push_back('{is_d: 1'b0, addr: iq[ii].addr, wdata: iq[ii].data});
          ii++;
        end
      end
    end
    auto_mode = 1;
    fork
      drive(1'b0);
      drive(1'b1);
    join
    repeat (3) tick();
    auto_mode = 0;
    oresp = '0;
    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
